// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display controller:
// the hex-to-segment table and the layout of a digit register entry.
package seg7_pkg;

    // Digit register entry layout: {dp, blank, value[3:0]}
    localparam int ENTRY_W   = 6;
    localparam int VAL_LSB   = 0;
    localparam int VAL_MSB   = 3;
    localparam int BLANK_BIT = 4;
    localparam int DP_BIT    = 5;

    // Active-high segment patterns, bit order gfedcba
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timing for the display: slot divider, digit index, free-running
// PWM counter and end-of-frame pulse.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int SCAN_DIV    = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int BRIGHT_W    = 4,
    parameter int IDX_W       = 3
) (
    input  logic                clk_i,
    input  logic                reset_i,
    output logic [IDX_W-1:0]    scan_idx_o,
    output logic [BRIGHT_W-1:0] pwm_cnt_o,
    output logic                slot_active_o,
    output logic                frame_done_o
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0]    div_cnt_q,    div_cnt_d;
    logic [IDX_W-1:0]    scan_idx_q,   scan_idx_d;
    logic [BRIGHT_W-1:0] pwm_cnt_q,    pwm_cnt_d;
    logic                frame_done_q, frame_done_d;

    // Next-state: divider wraps at terminal count, advancing the digit index;
    // wrapping the index past the last digit raises the frame pulse.
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_cnt_d    = div_cnt_q + DIV_W'(1);
        scan_idx_d   = scan_idx_q;
        frame_done_d = 1'b0;
        pwm_cnt_d    = pwm_cnt_q + BRIGHT_W'(1);
        if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt_d = '0;
            if (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                scan_idx_d   = '0;
                frame_done_d = 1'b1;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end
        end
    end

    // Timer state registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_cnt_q    <= '0;
            scan_idx_q   <= '0;
            pwm_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            scan_idx_q   <= scan_idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign scan_idx_o    = scan_idx_q;
    assign pwm_cnt_o     = pwm_cnt_q;
    assign slot_active_o = (div_cnt_q >= DIV_W'(DEAD_CYCLES));
    assign frame_done_o  = frame_done_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display controller: per-digit registers,
// brightness register, lit decision, hex decode and registered pin drivers.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYCLES    = 500,
    parameter int BRIGHT_W       = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0]    wr_data,
    input  logic                  bright_wr,
    input  logic [BRIGHT_W-1:0]   bright_data,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig,
    output logic [IDX_W-1:0]      scan_idx,
    output logic                  frame_done
);

    // Inactive pin levels; XOR-ing an active-high pattern with these applies polarity.
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic [ENTRY_W-1:0]    ENTRY_RESET = ENTRY_W'(1) << BLANK_BIT;

    logic [IDX_W-1:0]    tmr_scan_idx;
    logic [BRIGHT_W-1:0] tmr_pwm_cnt;
    logic                tmr_slot_active;
    logic                tmr_frame_done;

    logic [ENTRY_W-1:0]    entry_q [NUM_DIGITS];
    logic [BRIGHT_W-1:0]   bright_q;
    logic [ENTRY_W-1:0]    cur_entry;
    logic                  bright_ok;
    logic                  lit;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] dig_d;

    seg7_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .BRIGHT_W    (BRIGHT_W),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk_i         (CLK),
        .reset_i       (RESET),
        .scan_idx_o    (tmr_scan_idx),
        .pwm_cnt_o     (tmr_pwm_cnt),
        .slot_active_o (tmr_slot_active),
        .frame_done_o  (tmr_frame_done)
    );

    // Digit register file; writes to addresses beyond the digit count are dropped.
    // NOTE: this small register file is reset explicitly because every entry must power up blank.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                entry_q[i] <= ENTRY_RESET;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
            entry_q[wr_addr] <= wr_data;
        end
    end

    // Brightness register, full brightness out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bright_q <= '1;
        end else if (bright_wr) begin
            bright_q <= bright_data;
        end
    end

    // Lit decision and decode of the current slot's entry into pin levels.
    always_comb begin
        cur_entry = entry_q[tmr_scan_idx];
        bright_ok = (bright_q == '1) || (tmr_pwm_cnt < bright_q);
        lit       = enable && tmr_slot_active && !cur_entry[BLANK_BIT] && bright_ok;
        seg_d     = SEG_OFF;
        dp_d      = DP_OFF;
        dig_d     = DIG_OFF;
        if (lit) begin
            seg_d = SEG_OFF ^ hex_to_seg(cur_entry[VAL_MSB:VAL_LSB]);
            dp_d  = DP_OFF ^ cur_entry[DP_BIT];
            dig_d = DIG_OFF ^ (NUM_DIGITS'(1) << tmr_scan_idx);
        end
    end

    // Output registers: pins reflect the previous cycle's scan state and registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig        <= DIG_OFF;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp         <= dp_d;
            dig        <= dig_d;
            scan_idx   <= tmr_scan_idx;
            frame_done <= tmr_frame_done;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4-digit instance for the main scenarios,
// 3-digit instance for dropped out-of-range writes.
module tb_seg7_scan_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [5:0] wr_data;
    logic       bright_wr;
    logic [1:0] bright_data;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic [1:0] scan_idx;
    logic       frame_done;

    logic       wr_en3;
    logic [1:0] wr_addr3;
    logic [5:0] wr_data3;
    logic [6:0] seg3;
    logic       dp3;
    logic [2:0] dig3;
    logic [1:0] scan_idx3;
    logic       frame_done3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [6:0] act_tbl [4] = '{7'h06, 7'h5B, 7'h4F, 7'h66};

    always #5 CLK = ~CLK;

    // Edges since the last reset edge; outputs seen at cyc=t reflect scan state t-1.
    always @(posedge CLK) begin
        if (RESET) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    seg7_scan_ctrl #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYCLES(2), .BRIGHT_W(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) u_dut (
        .CLK(CLK), .RESET(RESET), .enable(enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .bright_wr(bright_wr), .bright_data(bright_data),
        .seg(seg), .dp(dp), .dig(dig), .scan_idx(scan_idx), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(3), .SCAN_DIV(4), .DEAD_CYCLES(1), .BRIGHT_W(2),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) u_dut3 (
        .CLK(CLK), .RESET(RESET), .enable(enable),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .bright_wr(1'b0), .bright_data(2'd0),
        .seg(seg3), .dp(dp3), .dig(dig3), .scan_idx(scan_idx3), .frame_done(frame_done3)
    );

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic write_digit(input logic [1:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_bright(input logic [1:0] b);
        bright_wr = 1'b1; bright_data = b;
        tick();
        bright_wr = 1'b0;
    endtask

    task automatic wait_phase(input int ph, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (cyc % 32 == ph) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        n_checks++; if (dig !== 4'hF)     begin n_fail++; $display("FAIL reset_dig: got %h expected F", dig); end
        n_checks++; if (seg !== 7'h7F)    begin n_fail++; $display("FAIL reset_seg: got %h expected 7F", seg); end
        n_checks++; if (dp !== 1'b1)      begin n_fail++; $display("FAIL reset_dp: got %b expected 1", dp); end
        n_checks++; if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL reset_scan_idx: got %0d expected 0", scan_idx); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        RESET  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_no_writes();
        for (int i = 0; i < 64; i++) begin
            tick();
            n_checks++;
            if (dig !== 4'hF || seg !== 7'h7F) begin
                n_fail++; $display("FAIL blank_after_reset t=%0d: got dig=%h seg=%h expected F/7F", cyc, dig, seg);
            end
        end
    endtask

    task automatic test_scan();
        int s, dv, ix, pulses;
        logic [3:0] e_dig; logic [6:0] e_seg; logic e_dp, e_fd;
        write_digit(2'd0, 6'h01);
        write_digit(2'd1, 6'h02);
        write_digit(2'd2, 6'h23);   // digit 2 also lights its decimal point
        write_digit(2'd3, 6'h04);
        tick(); tick();
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            s  = cyc - 1;
            dv = s % 8;
            ix = (s / 8) % 4;
            e_dig = (dv >= 2) ? ~(4'b0001 << ix) : 4'hF;
            e_seg = (dv >= 2) ? ~act_tbl[ix] : 7'h7F;
            e_dp  = !((dv >= 2) && (ix == 2));
            e_fd  = (s > 0) && (s % 32 == 0);
            if (frame_done === 1'b1) pulses++;
            n_checks++; if (dig !== e_dig) begin n_fail++; $display("FAIL scan_dig t=%0d: got %h expected %h", cyc, dig, e_dig); end
            n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL scan_seg t=%0d: got %h expected %h", cyc, seg, e_seg); end
            n_checks++; if (dp !== e_dp)   begin n_fail++; $display("FAIL scan_dp t=%0d: got %b expected %b", cyc, dp, e_dp); end
            n_checks++; if (scan_idx !== 2'(ix)) begin n_fail++; $display("FAIL scan_idx t=%0d: got %0d expected %0d", cyc, scan_idx, ix); end
            n_checks++; if (frame_done !== e_fd) begin n_fail++; $display("FAIL frame_done t=%0d: got %b expected %b", cyc, frame_done, e_fd); end
        end
        n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL frame_pulse_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_pwm();
        int s, dv, ix, pw;
        logic [3:0] e_dig; logic [6:0] e_seg;
        write_bright(2'd1);
        tick(); tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            s = cyc - 1; dv = s % 8; ix = (s / 8) % 4; pw = s % 4;
            e_dig = (dv >= 2 && pw == 0) ? ~(4'b0001 << ix) : 4'hF;
            n_checks++; if (dig !== e_dig) begin n_fail++; $display("FAIL pwm_bright1 t=%0d: got %h expected %h", cyc, dig, e_dig); end
        end
        write_bright(2'd0);
        tick(); tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            n_checks++; if (dig !== 4'hF) begin n_fail++; $display("FAIL pwm_bright0 t=%0d: got %h expected F", cyc, dig); end
        end
        // brightness and digit write in the same cycle: both must land
        bright_wr = 1'b1; bright_data = 2'd2;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'h07;
        tick();
        bright_wr = 1'b0; wr_en = 1'b0;
        tick(); tick();
        act_tbl[1] = 7'h07;
        for (int i = 0; i < 32; i++) begin
            tick();
            s = cyc - 1; dv = s % 8; ix = (s / 8) % 4; pw = s % 4;
            e_dig = (dv >= 2 && pw < 2) ? ~(4'b0001 << ix) : 4'hF;
            e_seg = (dv >= 2 && pw < 2) ? ~act_tbl[ix] : 7'h7F;
            n_checks++; if (dig !== e_dig) begin n_fail++; $display("FAIL pwm_bright2_dig t=%0d: got %h expected %h", cyc, dig, e_dig); end
            n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL pwm_bright2_seg t=%0d: got %h expected %h", cyc, seg, e_seg); end
        end
        write_bright(2'd3);
    endtask

    task automatic test_write_live();
        bit ok;
        wait_phase(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL live_wait: got timeout expected phase 4"); end
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'h0A;
        tick();
        wr_en = 1'b0;
        n_checks++; if (seg !== 7'h79) begin n_fail++; $display("FAIL live_seg_1cyc: got %h expected 79", seg); end
        n_checks++; if (dig !== 4'hE)  begin n_fail++; $display("FAIL live_dig: got %h expected E", dig); end
        tick();
        n_checks++; if (seg !== 7'h08) begin n_fail++; $display("FAIL live_seg_2cyc: got %h expected 08", seg); end
    endtask

    task automatic test_enable();
        bit ok;
        int ix;
        wait_phase(12, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL enable_wait: got timeout expected phase 12"); end
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ix = ((cyc - 1) / 8) % 4;
            n_checks++; if (dig !== 4'hF) begin n_fail++; $display("FAIL enable_off_dig t=%0d: got %h expected F", cyc, dig); end
            n_checks++; if (scan_idx !== 2'(ix)) begin n_fail++; $display("FAIL enable_off_idx t=%0d: got %0d expected %0d", cyc, scan_idx, ix); end
        end
        enable = 1'b1;
        tick();
        n_checks++; if (dig !== 4'hB)   begin n_fail++; $display("FAIL enable_resume_dig: got %h expected B", dig); end
        n_checks++; if (seg !== 7'h30)  begin n_fail++; $display("FAIL enable_resume_seg: got %h expected 30", seg); end
        n_checks++; if (scan_idx !== 2'd2) begin n_fail++; $display("FAIL enable_resume_idx: got %0d expected 2", scan_idx); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_phase(20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_mid_wait: got timeout expected phase 20"); end
        RESET = 1'b1;
        tick();
        n_checks++; if (scan_idx !== 2'd0) begin n_fail++; $display("FAIL reset_mid_idx: got %0d expected 0", scan_idx); end
        n_checks++; if (dig !== 4'hF)      begin n_fail++; $display("FAIL reset_mid_dig: got %h expected F", dig); end
        n_checks++; if (seg !== 7'h7F)     begin n_fail++; $display("FAIL reset_mid_seg: got %h expected 7F", seg); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_fd: got %b expected 0", frame_done); end
        RESET = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            n_checks++; if (dig !== 4'hF) begin n_fail++; $display("FAIL reset_mid_blank t=%0d: got %h expected F", cyc, dig); end
        end
    endtask

    task automatic test_invalid_addr();
        bit seen;
        wr_en3 = 1'b1; wr_addr3 = 2'd3; wr_data3 = 6'h08;
        tick();
        wr_en3 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++; if (dig3 !== 3'b111 || seg3 !== 7'h7F) begin
                n_fail++; $display("FAIL invalid_addr t=%0d: got dig=%h seg=%h expected 7/7F", cyc, dig3, seg3);
            end
        end
        wr_en3 = 1'b1; wr_addr3 = 2'd2; wr_data3 = 6'h08;
        tick();
        wr_en3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (dig3 === 3'b011 && seg3 === 7'h00) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL valid_addr_lit: got never lit expected dig=3 seg=00"); end
    endtask

    initial begin
        RESET = 1'b1; enable = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bright_wr = 1'b0; bright_data = '0;
        wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0;
        tick(); tick();
        test_reset();
        test_no_writes();
        test_scan();
        test_pwm();
        test_write_live();
        test_enable();
        test_reset_mid();
        test_invalid_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
